// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    LDR_ACC = 2'd2
  } arb_state_e;

  localparam int MAX_WAIT_LIM = 15;
  localparam int WAIT_W       = 4;
  localparam int STAT_W       = 16;

endpackage

// File: rtl/arb_wait_ctr.sv
// CPU starvation guard: saturating count of cycles the CPU has waited,
// flagged once it reaches MAX_WAIT.
module arb_wait_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != WAIT_W'(MAX_WAIT_LIM)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q >= WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter for the single unified memory port.
// Optional grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             ldr_req,
  input  logic             ldr_we,
  input  logic [WIDTH-1:0] ldr_addr,
  input  logic [WIDTH-1:0] ldr_wdata,
  output logic             ldr_gnt,
  output logic             ldr_rvalid,
  output logic [WIDTH-1:0] ldr_rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] cpu_gnt_cnt,
  output logic [STAT_W-1:0] ldr_gnt_cnt
`endif
);

  arb_state_e state_q, state_d;
  logic       cpu_rvalid_q, ldr_rvalid_q;
  logic [WIDTH-1:0] cpu_rdata_q, ldr_rdata_q;
  logic       eff_c, eff_l, cpu_prio;

  assign cpu_gnt = (state_q == CPU_ACC);
  assign ldr_gnt = (state_q == LDR_ACC);

  // The port holding the grant is masked so it cannot be re-granted next cycle.
  assign eff_c = cpu_req && !cpu_gnt;
  assign eff_l = ldr_req && !ldr_gnt;

  assign cpu_stall = eff_c && reset;

  arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk       (clk),
    .rst_n     (reset),
    .inc_i     (eff_c),
    .clr_i     (cpu_gnt),
    .expired_o (cpu_prio)
  );

  always_comb begin
    state_d = IDLE;
    if (eff_c && eff_l) state_d = cpu_prio ? CPU_ACC : LDR_ACC;
    else if (eff_c)     state_d = CPU_ACC;
    else if (eff_l)     state_d = LDR_ACC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      ldr_rvalid_q <= ldr_gnt && !ldr_we;
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= mem_rdata;
      if (ldr_gnt && !ldr_we) ldr_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      CPU_ACC: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      LDR_ACC: begin
        mem_we    = ldr_we;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] cpu_cnt_q, ldr_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_cnt_q <= '0;
      ldr_cnt_q <= '0;
    end else begin
      if (cpu_gnt) cpu_cnt_q <= cpu_cnt_q + 1'b1;
      if (ldr_gnt) ldr_cnt_q <= ldr_cnt_q + 1'b1;
    end
  end

  assign cpu_gnt_cnt = cpu_cnt_q;
  assign ldr_gnt_cnt = ldr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_mem_arbiter;
  localparam int WIDTH    = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [WIDTH-1:0] cpu_addr = '0, cpu_wdata = '0;
  logic ldr_req = 1'b0, ldr_we = 1'b0;
  logic [WIDTH-1:0] ldr_addr = '0, ldr_wdata = '0;
  logic cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid, mem_we;
  logic [WIDTH-1:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt, ldr_gnt_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Model: owner 0=none 1=cpu 2=loader, plus wait count, read returns, counters
  int m_own, m_wait, m_ccnt, m_lcnt;
  logic m_crv, m_lrv;
  logic [WIDTH-1:0] m_crd, m_lrd;

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] memf(input logic [WIDTH-1:0] a);
    if (a == 32'h8) return 32'h2002_0005;
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1};
  endfunction

  assign mem_rdata = memf(mem_addr);

  mem_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .cpu_gnt_cnt(cpu_gnt_cnt), .ldr_gnt_cnt(ldr_gnt_cnt)
`endif
  );

  task automatic model_reset();
    m_own = 0; m_wait = 0; m_ccnt = 0; m_lcnt = 0;
    m_crv = 1'b0; m_lrv = 1'b0; m_crd = '0; m_lrd = '0;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [WIDTH-1:0] ca,
                       input logic [WIDTH-1:0] cd, input logic lr, input logic lw,
                       input logic [WIDTH-1:0] la, input logic [WIDTH-1:0] ld);
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
    #1;
  endtask

  // Apply the arbitration rules to the current inputs, then take the clock edge.
  task automatic advance();
    int nxt;
    logic ec, el;
    if (!reset) model_reset();
    else begin
      ec = cpu_req && (m_own != 1);
      el = ldr_req && (m_own != 2);
      if (ec && el)  nxt = (m_wait >= MAX_WAIT) ? 1 : 2;
      else if (ec)   nxt = 1;
      else if (el)   nxt = 2;
      else           nxt = 0;
      m_crv = (m_own == 1) && !cpu_we;
      m_lrv = (m_own == 2) && !ldr_we;
      if (m_crv) m_crd = memf(cpu_addr);
      if (m_lrv) m_lrd = memf(ldr_addr);
      if (m_own == 1)   m_wait = 0;
      else if (cpu_req) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
      if (m_own == 1) m_ccnt = (m_ccnt + 1) % 65536;
      if (m_own == 2) m_lcnt = (m_lcnt + 1) % 65536;
      m_own = nxt;
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
    checks++;
    if ({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_we, cpu_stall} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_we, cpu_stall});
    end
    checks++;
    if ({cpu_rdata, ldr_rdata, mem_addr} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {cpu_rdata, ldr_rdata, mem_addr});
    end
    advance();
    drive(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    checks++;
    if ({cpu_gnt, cpu_stall} !== 2'b01) begin
      failures++; $display("FAIL reset_release got=%b exp=01", {cpu_gnt, cpu_stall});
    end
    advance();
    drive(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_gnt, mem_addr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL reset_first_gnt got=%b/%h exp=1/0", cpu_gnt, mem_addr);
    end
    advance();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    advance();
  endtask

  task automatic test_cpu_read();
    drive(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_gnt, cpu_rvalid} !== 2'b00) begin
      failures++; $display("FAIL rd_pre got=%b exp=00", {cpu_gnt, cpu_rvalid});
    end
    advance();
    drive(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_gnt, mem_we, mem_addr} !== {2'b10, 32'h8}) begin
      failures++; $display("FAIL rd_gnt got=%b%b/%h exp=10/8", cpu_gnt, mem_we, mem_addr);
    end
    advance();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h2002_0005}) begin
      failures++; $display("FAIL rd_data got=%b/%h exp=1/20020005", cpu_rvalid, cpu_rdata);
    end
    advance();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 32'h2002_0005}) begin
      failures++; $display("FAIL rd_hold got=%b/%h exp=0/20020005", cpu_rvalid, cpu_rdata);
    end
    advance();
  endtask

  task automatic test_ldr_write();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    advance();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if ({ldr_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h10, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL ldr_wr got=%b%b/%h/%h exp=11/10/deadbeef", ldr_gnt, mem_we, mem_addr, mem_wdata);
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      checks++;
      if ({ldr_gnt, mem_we, ldr_rvalid} !== 3'b000) begin
        failures++; $display("FAIL ldr_wr_after got=%b exp=000", {ldr_gnt, mem_we, ldr_rvalid});
      end
      advance();
    end
  endtask

  task automatic test_contention();
    // Continuous requests from idle: loader first, then CPU
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0);
      checks++;
      if ({cpu_gnt, ldr_gnt, cpu_stall} !== ((c == 0) ? 3'b001 : (c == 1) ? 3'b011 : 3'b100)) begin
        failures++; $display("FAIL cont_start c=%0d got=%b", c, {cpu_gnt, ldr_gnt, cpu_stall});
      end
      advance();
    end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    advance();
    // CPU loses four arbitrations (dropping its request each time), then wins
    for (int r = 0; r < 5; r++) begin
      drive(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0);
      checks++;
      if ({cpu_gnt, ldr_gnt, cpu_stall} !== 3'b001) begin
        failures++; $display("FAIL cont_wait r=%0d got=%b exp=001", r, {cpu_gnt, ldr_gnt, cpu_stall});
      end
      advance();
      if (r < 4) begin
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        checks++;
        if ({cpu_gnt, ldr_gnt} !== 2'b01) begin
          failures++; $display("FAIL cont_ldr r=%0d got=%b exp=01", r, {cpu_gnt, ldr_gnt});
        end
        advance();
      end
    end
    drive(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0);
    checks++;
    if ({cpu_gnt, ldr_gnt, cpu_stall} !== 3'b100) begin
      failures++; $display("FAIL cont_prio got=%b exp=100", {cpu_gnt, ldr_gnt, cpu_stall});
    end
    advance();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h34, 32'h0);
    advance();
    // Cleared counter: loader wins the next contested arbitration
    drive(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0);
    advance();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_gnt, ldr_gnt} !== 2'b01) begin
      failures++; $display("FAIL cont_clear got=%b exp=01", {cpu_gnt, ldr_gnt});
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
      checks++;
      if ({cpu_gnt, cpu_rvalid} !== {1'(i % 2), 1'(i >= 2 && i % 2 == 0)}) begin
        failures++; $display("FAIL b2b i=%0d got=%b", i, {cpu_gnt, cpu_rvalid});
      end
      advance();
    end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    advance();
  endtask

  task automatic test_reset_mid_read();
    drive(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
    advance();
    drive(1, 1, 32'h8, 32'h55, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_gnt, mem_we} !== 2'b11) begin
      failures++; $display("FAIL mid_gnt got=%b exp=11", {cpu_gnt, mem_we});
    end
    cpu_we = 1'b0;
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({cpu_gnt, mem_we, cpu_stall, mem_addr} !== 35'h0) begin
      failures++; $display("FAIL mid_abort got=%b%b%b/%h exp=0", cpu_gnt, mem_we, cpu_stall, mem_addr);
    end
    advance();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cpu_rvalid !== 1'b0) begin
        failures++; $display("FAIL mid_no_rvalid i=%0d got=%b exp=0", i, cpu_rvalid);
      end
      advance();
      drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    end
    advance();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_gnt_cnt, ldr_gnt_cnt} !== 32'h0) begin
      failures++; $display("FAIL stats_reset got=%h/%h exp=0/0", cpu_gnt_cnt, ldr_gnt_cnt);
    end
    advance();
    drive(1, 0, 32'h50, 32'h0, 1, 0, 32'h54, 32'h0);
    advance();
    drive(1, 0, 32'h50, 32'h0, 1, 0, 32'h54, 32'h0);
    advance();
    drive(1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0);
    advance();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({cpu_gnt_cnt, ldr_gnt_cnt} !== {16'd1, 16'd1}) begin
      failures++; $display("FAIL stats_count got=%0d/%0d exp=1/1", cpu_gnt_cnt, ldr_gnt_cnt);
    end
    advance();
  endtask
`endif

  task automatic test_random();
    logic e_we;
    logic [WIDTH-1:0] e_addr, e_wd;
    for (int n = 0; n < 500; n++) begin
      drive(($urandom % 3) != 0, 1'($urandom), WIDTH'($urandom % 64), $urandom,
            1'($urandom), 1'($urandom), WIDTH'($urandom % 64), $urandom);
      if (($urandom % 61) == 0) begin
        reset = 1'b0; model_reset(); #1;
      end else if (!reset) begin
        reset = 1'b1; #1;
      end
      e_we   = (m_own == 1) ? cpu_we    : (m_own == 2) ? ldr_we    : 1'b0;
      e_addr = (m_own == 1) ? cpu_addr  : (m_own == 2) ? ldr_addr  : '0;
      e_wd   = (m_own == 1) ? cpu_wdata : (m_own == 2) ? ldr_wdata : '0;
      checks++;
      if ({cpu_gnt, ldr_gnt, cpu_stall} !==
          {m_own == 1, m_own == 2, cpu_req && (m_own != 1) && reset}) begin
        failures++;
        $display("FAIL rnd_ctl n=%0d got=%b own=%0d", n, {cpu_gnt, ldr_gnt, cpu_stall}, m_own);
      end
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wd}) begin
        failures++;
        $display("FAIL rnd_mem n=%0d got=%b/%h/%h exp=%b/%h/%h", n, mem_we, mem_addr, mem_wdata,
                 e_we, e_addr, e_wd);
      end
      checks++;
      if ({cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata} !== {m_crv, m_crd, m_lrv, m_lrd}) begin
        failures++;
        $display("FAIL rnd_rd n=%0d got=%b/%h %b/%h exp=%b/%h %b/%h", n, cpu_rvalid, cpu_rdata,
                 ldr_rvalid, ldr_rdata, m_crv, m_crd, m_lrv, m_lrd);
      end
`ifdef MEM_ARB_STATS_EN
      checks++;
      if ({cpu_gnt_cnt, ldr_gnt_cnt} !== {16'(m_ccnt), 16'(m_lcnt)}) begin
        failures++;
        $display("FAIL rnd_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, cpu_gnt_cnt, ldr_gnt_cnt, m_ccnt, m_lcnt);
      end
`endif
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_contention();
    test_back_to_back();
    test_reset_mid_read();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory_system port of the multicycle datapath between two requesters:
  - port C: the CPU fetch/load/store path (address mux, RD2 write data, MemWrite).
  - port L: the program loader / debug writer.
- Registered grant FSM, 1-cycle read return and a starvation guard for the CPU.
- Exports cpu_stall, which the control FSM uses to hold PCWrite/IRWrite while memory is busy.

Parameters:
- WIDTH, 32, data and address width.
- MAX_WAIT, 4, consecutive cycles the CPU may wait before it gets priority over the loader (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  WIDTH  CPU byte address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_gnt  out  1  CPU owns memory this cycle.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  WIDTH  CPU read data.
- cpu_stall  out  1  cpu_req && !cpu_gnt (combinational).
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata: same as the cpu_* ports, for the loader.
- mem_we  out  1  to memory_system while_enable_i.
- mem_addr  out  WIDTH  to memory_system address_i.
- mem_wdata  out  WIDTH  to memory_system write_data.
- mem_rdata  in  WIDTH  from memory_system instruction_o (combinational read).

Behaviour:
- Reset (reset=0, asynchronous): all of the following are 0:
  - state = IDLE.
  - wait counter.
  - cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid.
  - cpu_rdata, ldr_rdata.
  - mem_we.
- States: IDLE, CPU_ACC, LDR_ACC; the state register is the grant.
- Outputs by state:
  - In CPU_ACC: mem_* is driven from the cpu_* inputs, cpu_gnt=1.
  - In LDR_ACC: mem_* is driven from the ldr_* inputs, ldr_gnt=1.
  - In IDLE: mem_we=0, mem_addr=0, mem_wdata=0.
- Effective requests for next-state logic: eC = cpu_req && !cpu_gnt, eL = ldr_req && !ldr_gnt. The port served this cycle is never re-granted next cycle, so a same-port back-to-back access takes at least 2 cycles.
- Next state, evaluated every cycle in any state:
  - eC and eL both set, wait >= MAX_WAIT -> CPU_ACC.
  - eC and eL both set otherwise -> LDR_ACC.
  - only eC -> CPU_ACC.
  - only eL -> LDR_ACC.
  - neither -> IDLE.
- Wait counter (4 bits):
  - +1 each cycle cpu_req && !cpu_gnt, saturating at 15.
  - cleared on any cycle with cpu_gnt=1.
- Grant-to-data latency:
  - Read (we=0) granted in cycle N: mem_rdata is captured at the end of N. The port's rdata and rvalid=1 are presented in cycle N+1; rvalid is high for exactly 1 cycle.
  - Write (we=1): memory written at the end of the grant cycle; no rvalid.
  - rdata holds its last value between reads.
- Requester contract: req/we/addr/wdata stay stable from req rise through the gnt cycle, and req drops the cycle after gnt. A violation is not detected; the arbiter uses whatever values are present in the grant cycle.
- Address bits [1:0] pass through unchanged; alignment is the requester's responsibility.
- Reset asserted mid-access: the access is abandoned, no rvalid follows, and the memory write is not performed if reset arrives before the clock edge.
- cpu_stall is 0 during reset and whenever cpu_req=0.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs cpu_gnt_cnt and ldr_gnt_cnt (16 bits each).
  - Each counts grant cycles of its port, wraps 0xFFFF->0, and resets to 0.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE=2'd0, CPU_ACC=2'd1, LDR_ACC=2'd2.
  - MAX_WAIT upper bound 15.
  - wait counter width 4.
- One natural sub-module: arb_wait_ctr (saturating wait counter with clear, and the compare against MAX_WAIT). Everything else stays in mem_arbiter.

Test Plan:
- Reset: reset=0 with both ports requesting -> no gnt, no rvalid, mem_we=0. After reset=1, the CPU request alone (cpu_addr=0x0) gives cpu_gnt in the next cycle.
- CPU read: cpu_req with cpu_addr=0x8 and mem returning 0x2002_0005 -> cpu_gnt in cycle N, cpu_rvalid=1 with cpu_rdata=0x2002_0005 in N+1, cpu_rvalid=0 in N+2.
- Loader write: ldr_req, ldr_we=1, ldr_addr=0x10, ldr_wdata=0xDEAD_BEEF -> one cycle with mem_we=1, mem_addr=0x10, mem_wdata=0xDEAD_BEEF; ldr_rvalid stays 0.
- Contention:
  - Both ports request continuously, MAX_WAIT=4 -> the loader is granted first.
  - The CPU is granted on the first arbitration after its wait count reaches 4.
  - The counter then clears.
  - cpu_stall=1 every cycle the CPU waits.
- Back-to-back: cpu_req held high across its grant -> at least one non-CPU_ACC cycle between CPU grants.
- Reset mid-read: reset=0 during CPU_ACC -> no cpu_rvalid ever follows. With MEM_ARB_STATS_EN defined, the counters read 0 after reset and show 1 and 1 after one CPU grant and one loader grant.
